// File: rtl/prim_range_dispatch_pkg.sv
// Shared types and constants for the leaf-range dispatcher.
// Widths here are the defaults the dispatcher parameters pick up.
package prim_range_dispatch_pkg;

   localparam int BVH_PRIMITIVE_INDEX_WIDTH  = 16;
   localparam int BVH_PRIMITIVE_AMOUNT_WIDTH = 4;
   localparam int PRIM_QUEUE_DEPTH           = 8;

   localparam logic [BVH_PRIMITIVE_INDEX_WIDTH-1:0] NULL_PRIMITIVE_INDEX = '1;

   typedef struct packed {
      logic [BVH_PRIMITIVE_INDEX_WIDTH-1:0]  start;
      logic [BVH_PRIMITIVE_AMOUNT_WIDTH-1:0] num;
   } PrimRange;

   typedef enum logic [1:0] {
      PDS_Idle,
      PDS_Active,
      PDS_Done
   } PrimDispatchState;

endpackage

// File: rtl/prim_range_fifo.sv
// Circular range buffer: two ordered writes and one read per cycle.
// Callers gate writes against the start-of-cycle count.
module prim_range_fifo #(
   parameter int DEPTH = 8,
   parameter int W     = 20,
   localparam int AW   = $clog2(DEPTH),
   localparam int CW   = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          clr,
   input  logic          wr0_en,
   input  logic [W-1:0]  wr0_data,
   input  logic          wr1_en,
   input  logic [W-1:0]  wr1_data,
   input  logic          rd_en,
   output logic [W-1:0]  head,
   output logic [CW-1:0] count,
   output logic          empty
);

   logic [W-1:0]  mem_q [DEPTH];
   logic [W-1:0]  mem_d [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [AW-1:0] wr_ptr_nxt;

   assign wr_ptr_nxt = wr_ptr_q + AW'(1);

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (clr) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (wr0_en) mem_d[wr_ptr_q] = wr0_data;
         // slot 1 lands behind slot 0 only when slot 0 also wrote
         if (wr1_en) mem_d[wr0_en ? wr_ptr_nxt : wr_ptr_q] = wr1_data;
         wr_ptr_d = wr_ptr_q + AW'(wr0_en) + AW'(wr1_en);
         rd_ptr_d = rd_ptr_q + AW'(rd_en);
         count_d  = count_q + CW'(wr0_en) + CW'(wr1_en) - CW'(rd_en);
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign head  = mem_q[rd_ptr_q];
   assign count = count_q;
   assign empty = (count_q == '0);

endmodule

// File: rtl/prim_range_dispatch.sv
// Queues leaf ranges from traversal and issues one primitive per handshake.
// Flags ray completion, near-full hold hint and sticky range loss.
module prim_range_dispatch
   import prim_range_dispatch_pkg::*;
#(
   parameter int PRIM_IDX_W  = BVH_PRIMITIVE_INDEX_WIDTH,
   parameter int PRIM_NUM_W  = BVH_PRIMITIVE_AMOUNT_WIDTH,
   parameter int QUEUE_DEPTH = PRIM_QUEUE_DEPTH
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  start,
   input  logic [PRIM_IDX_W-1:0] range_start [2],
   input  logic [PRIM_NUM_W-1:0] range_num [2],
   input  logic                  bvh_finished,
   output logic                  prim_valid,
   output logic [PRIM_IDX_W-1:0] prim_index,
   output logic                  prim_last_in_range,
   input  logic                  prim_ready,
   output logic                  done,
   output logic                  almost_full,
   output logic                  overflow
);

   localparam int CW = $clog2(QUEUE_DEPTH) + 1;
   localparam int EW = PRIM_IDX_W + PRIM_NUM_W;
   localparam logic [PRIM_IDX_W-1:0] NullIdx = PRIM_IDX_W'(NULL_PRIMITIVE_INDEX);

   PrimDispatchState state_q, state_d;
   logic                  seen_busy_q, seen_busy_d;
   logic                  overflow_q, overflow_d;
   logic [PRIM_IDX_W-1:0] cur_idx_q, cur_idx_d;
   logic [PRIM_NUM_W-1:0] rem_q, rem_d;

   logic [EW-1:0]         head;
   logic [CW-1:0]         count;
   logic [CW-1:0]         free;
   logic                  fifo_empty;
   logic                  active, v0, v1, acc0, acc1, drop, hs, load;

   assign active = (state_q == PDS_Active) && !start;
   assign v0 = active && (range_num[0] != '0) && (range_start[0] != NullIdx);
   assign v1 = active && (range_num[1] != '0) && (range_start[1] != NullIdx);
   assign free = CW'(QUEUE_DEPTH) - count;
   assign acc0 = v0 && (free != '0);
   assign acc1 = v1 && (v0 ? (free >= CW'(2)) : (free != '0));
   assign drop = (v0 && !acc0) || (v1 && !acc1);

   assign hs = (rem_q != '0) && prim_ready && !start;
   // last-index handshake reloads from the head in the same edge
   assign load = !start && !fifo_empty &&
                 ((rem_q == '0) || (hs && rem_q == PRIM_NUM_W'(1)));

   prim_range_fifo #(
      .DEPTH (QUEUE_DEPTH),
      .W     (EW)
   ) u_fifo (
      .clk      (clk),
      .resetn   (resetn),
      .clr      (start),
      .wr0_en   (acc0),
      .wr0_data ({range_start[0], range_num[0]}),
      .wr1_en   (acc1),
      .wr1_data ({range_start[1], range_num[1]}),
      .rd_en    (load),
      .head     (head),
      .count    (count),
      .empty    (fifo_empty)
   );

   always_comb begin
      cur_idx_d = cur_idx_q;
      rem_d     = rem_q;
      if (start) begin
         cur_idx_d = '0;
         rem_d     = '0;
      end else if (load) begin
         cur_idx_d = head[EW-1 -: PRIM_IDX_W];
         rem_d     = head[PRIM_NUM_W-1:0];
      end else if (hs) begin
         cur_idx_d = cur_idx_q + PRIM_IDX_W'(1);
         rem_d     = rem_q - PRIM_NUM_W'(1);
      end
   end

   always_comb begin
      state_d     = state_q;
      seen_busy_d = seen_busy_q;
      overflow_d  = overflow_q;
      unique case (state_q)
         PDS_Idle: begin
         end
         PDS_Active: begin
            seen_busy_d = seen_busy_q | ~bvh_finished;
            overflow_d  = overflow_q | drop;
            // a range arriving this cycle must not be stranded
            if (seen_busy_q && bvh_finished && fifo_empty &&
                rem_q == '0 && !v0 && !v1)
               state_d = PDS_Done;
         end
         PDS_Done: begin
         end
         default: state_d = PDS_Idle;
      endcase
      if (start) begin
         state_d     = PDS_Active;
         seen_busy_d = 1'b0;
         overflow_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= PDS_Idle;
         seen_busy_q <= 1'b0;
         overflow_q  <= 1'b0;
         cur_idx_q   <= '0;
         rem_q       <= '0;
      end else begin
         state_q     <= state_d;
         seen_busy_q <= seen_busy_d;
         overflow_q  <= overflow_d;
         cur_idx_q   <= cur_idx_d;
         rem_q       <= rem_d;
      end
   end

   assign prim_valid         = (rem_q != '0);
   assign prim_index         = cur_idx_q;
   assign prim_last_in_range = (rem_q == PRIM_NUM_W'(1));
   assign done               = (state_q == PDS_Done);
   assign almost_full        = (free < CW'(2));
   assign overflow           = overflow_q;

endmodule

// File: tb/tb_prim_range_dispatch.sv
// Directed and random bench for prim_range_dispatch against a
// queue-based reference of the range expansion rules.
module tb_prim_range_dispatch;
   import prim_range_dispatch_pkg::*;

   localparam int IW    = BVH_PRIMITIVE_INDEX_WIDTH;
   localparam int NW    = BVH_PRIMITIVE_AMOUNT_WIDTH;
   localparam int DEPTH = PRIM_QUEUE_DEPTH;

   logic          clk = 1'b0;
   logic          resetn, start, bvh_finished, prim_ready;
   logic [IW-1:0] range_start [2];
   logic [NW-1:0] range_num [2];
   logic          prim_valid, prim_last_in_range, done, almost_full, overflow;
   logic [IW-1:0] prim_index;

   prim_range_dispatch dut (
      .clk                (clk),
      .resetn             (resetn),
      .start              (start),
      .range_start        (range_start),
      .range_num          (range_num),
      .bvh_finished       (bvh_finished),
      .prim_valid         (prim_valid),
      .prim_index         (prim_index),
      .prim_last_in_range (prim_last_in_range),
      .prim_ready         (prim_ready),
      .done               (done),
      .almost_full        (almost_full),
      .overflow           (overflow)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc_n  = 0;

   // reference: 0 idle, 1 active, 2 done
   PrimRange      m_q[$];
   int            m_state;
   bit            m_seen, m_ovf;
   logic [IW-1:0] m_cur;
   int            m_rem;

   typedef struct {
      logic [IW-1:0] idx;
      bit            last;
      int            c;
   } obs_t;
   obs_t obs[$];

   task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
      checks++;
      assert (o === e) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, o, e, cyc_n);
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      m_state = 0;
      m_seen  = 0;
      m_ovf   = 0;
      m_cur   = '0;
      m_rem   = 0;
   endtask

   task automatic model_step();
      bit       hs, ld;
      bit       v [2];
      int       freeq;
      PrimRange r;
      hs = (m_rem != 0) && prim_ready;
      if (start) begin
         model_reset();
         m_state = 1;
         return;
      end
      if (m_state != 1) return;
      for (int k = 0; k < 2; k++)
         v[k] = (range_num[k] != 0) && (range_start[k] != NULL_PRIMITIVE_INDEX);
      freeq = DEPTH - m_q.size();
      if (m_seen && bvh_finished && m_q.size() == 0 && m_rem == 0 && !v[0] && !v[1])
         m_state = 2;
      ld = (m_q.size() > 0) && (m_rem == 0 || (hs && m_rem == 1));
      if (ld) begin
         r = m_q.pop_front();
         m_cur = r.start;
         m_rem = int'(r.num);
      end else if (hs) begin
         m_cur = m_cur + 1'b1;
         m_rem = m_rem - 1;
      end
      for (int k = 0; k < 2; k++) begin
         if (v[k]) begin
            if (freeq > 0) begin
               r.start = range_start[k];
               r.num   = range_num[k];
               m_q.push_back(r);
               freeq--;
            end else begin
               m_ovf = 1;
            end
         end
      end
      if (!bvh_finished) m_seen = 1;
   endtask

   task automatic compare_all();
      chk("valid", prim_valid, m_rem != 0);
      if (m_rem != 0) begin
         chk("index", prim_index, m_cur);
         chk("last", prim_last_in_range, m_rem == 1);
      end
      chk("done", done, m_state == 2);
      chk("almost_full", almost_full, (DEPTH - m_q.size()) < 2);
      chk("overflow", overflow, m_ovf);
   endtask

   task automatic cyc();
      if (prim_valid && prim_ready && !start)
         obs.push_back('{prim_index, prim_last_in_range, cyc_n});
      @(posedge clk);
      model_step();
      cyc_n++;
      #1;
      compare_all();
   endtask

   task automatic slots(input logic [IW-1:0] s0, input logic [NW-1:0] n0,
                        input logic [IW-1:0] s1, input logic [NW-1:0] n1);
      range_start[0] = s0;
      range_num[0]   = n0;
      range_start[1] = s1;
      range_num[1]   = n1;
   endtask

   task automatic new_ray();
      obs.delete();
      slots(0, 0, 0, 0);
      start = 1;
      cyc();
      start = 0;
   endtask

   task automatic wait_done(input int budget);
      int k = 0;
      slots(0, 0, 0, 0);
      bvh_finished = 1;
      prim_ready   = 1;
      while (!done && k < budget) begin
         cyc();
         k++;
      end
      chk("done_reached", done, 1);
   endtask

   task automatic check_stream(input string tag, input int ei[$], input bit el[$]);
      chk({tag, "_len"}, obs.size(), ei.size());
      for (int i = 0; i < ei.size() && i < obs.size(); i++) begin
         chk({tag, "_idx"}, obs[i].idx, ei[i]);
         chk({tag, "_last"}, obs[i].last, el[i]);
         if (i > 0) chk({tag, "_gap"}, obs[i].c - obs[i-1].c, 1);
      end
   endtask

   initial begin
      int ei[$];
      bit el[$];
      resetn = 0;
      start = 0;
      bvh_finished = 1;
      prim_ready = 0;
      slots(0, 0, 0, 0);
      model_reset();
      @(posedge clk);
      #1;
      chk("rst_valid", prim_valid, 0);
      chk("rst_index", prim_index, 0);
      chk("rst_last", prim_last_in_range, 0);
      chk("rst_done", done, 0);
      chk("rst_af", almost_full, 0);
      chk("rst_ovf", overflow, 0);
      resetn = 1;
      cyc();

      // single range
      new_ray();
      slots(16'd5, 4'd3, 0, 0);
      bvh_finished = 0;
      prim_ready = 1;
      cyc();
      chk("lat_n", prim_valid, 0);
      slots(0, 0, 0, 0);
      bvh_finished = 1;
      cyc();
      chk("lat_n1", prim_valid, 1);
      chk("lat_idx", prim_index, 5);
      repeat (3) cyc();
      chk("single_drained", prim_valid, 0);
      chk("single_notdone", done, 0);
      cyc();
      chk("single_done", done, 1);
      ei = '{5, 6, 7};
      el = '{0, 0, 1};
      check_stream("single", ei, el);

      // dual slot, no bubble across ranges
      new_ray();
      slots(16'd10, 4'd2, 16'd40, 4'd1);
      bvh_finished = 0;
      cyc();
      wait_done(50);
      ei = '{10, 11, 40};
      el = '{0, 1, 1};
      check_stream("dual", ei, el);

      // index wrap
      new_ray();
      slots(16'hFFFE, 4'd3, 0, 0);
      bvh_finished = 0;
      cyc();
      wait_done(50);
      ei = '{32'hFFFE, 32'hFFFF, 0};
      el = '{0, 0, 1};
      check_stream("wrap", ei, el);

      // backpressure
      new_ray();
      slots(16'd100, 4'd4, 0, 0);
      bvh_finished = 0;
      prim_ready = 1;
      cyc();
      slots(0, 0, 0, 0);
      cyc();
      prim_ready = 1; cyc();
      prim_ready = 0; cyc();
      chk("bp_hold", prim_index, 101);
      prim_ready = 0; cyc();
      chk("bp_hold2", prim_index, 101);
      prim_ready = 1; cyc();
      wait_done(50);
      ei = '{100, 101, 102, 103};
      el = '{0, 0, 0, 1};
      chk("bp_len", obs.size(), 4);
      for (int i = 0; i < 4 && i < obs.size(); i++)
         chk("bp_idx", obs[i].idx, ei[i]);

      // filtering and stale finished
      new_ray();
      bvh_finished = 1;
      slots(NULL_PRIMITIVE_INDEX, 4'd3, 16'd7, 4'd0);
      repeat (3) cyc();
      chk("filt_notdone", done, 0);
      chk("filt_valid", prim_valid, 0);
      slots(0, 0, 0, 0);
      bvh_finished = 0;
      cyc();
      chk("filt_busy_notdone", done, 0);
      bvh_finished = 1;
      cyc();
      chk("filt_done", done, 1);
      chk("filt_none", obs.size(), 0);

      // overflow
      new_ray();
      bvh_finished = 0;
      prim_ready = 0;
      for (int i = 0; i < 8; i++) begin
         slots(IW'(200 + i), 4'd1, 0, 0);
         cyc();
      end
      chk("ovf_pre", overflow, 0);
      chk("af_pre", almost_full, 1);
      slots(16'd300, 4'd1, 16'd999, 4'd1);
      cyc();
      chk("ovf_set", overflow, 1);
      chk("ovf_af", almost_full, 1);
      wait_done(100);
      ei = '{200, 201, 202, 203, 204, 205, 206, 207, 300};
      el = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
      check_stream("ovf", ei, el);
      chk("ovf_hold_done", overflow, 1);
      new_ray();
      chk("ovf_clr", overflow, 0);

      // start mid-range
      slots(16'd300, 4'd5, 16'd400, 4'd2);
      bvh_finished = 0;
      prim_ready = 1;
      cyc();
      slots(0, 0, 0, 0);
      repeat (3) cyc();
      start = 1;
      cyc();
      start = 0;
      chk("abort_valid", prim_valid, 0);
      chk("abort_af", almost_full, 0);
      obs.delete();
      slots(16'd500, 4'd2, 0, 0);
      cyc();
      wait_done(50);
      ei = '{500, 501};
      el = '{0, 1};
      check_stream("abort", ei, el);

      // reset mid-range
      new_ray();
      slots(16'd600, 4'd6, 0, 0);
      bvh_finished = 0;
      cyc();
      slots(0, 0, 0, 0);
      repeat (3) cyc();
      resetn = 0;
      #1;
      chk("rstmid_valid", prim_valid, 0);
      chk("rstmid_done", done, 0);
      chk("rstmid_af", almost_full, 0);
      model_reset();
      @(negedge clk);
      resetn = 1;
      new_ray();
      slots(16'd700, 4'd2, 0, 0);
      bvh_finished = 0;
      cyc();
      wait_done(50);
      ei = '{700, 701};
      el = '{0, 1};
      check_stream("rstmid", ei, el);

      // random rays against the reference
      for (int r = 0; r < 6; r++) begin
         new_ray();
         for (int c = 0; c < 60; c++) begin
            for (int k = 0; k < 2; k++) begin
               range_num[k] = NW'($urandom_range(0, 3));
               if ($urandom_range(0, 7) == 0)
                  range_start[k] = NULL_PRIMITIVE_INDEX;
               else if ($urandom_range(0, 9) == 0)
                  range_start[k] = 16'hFFFD;
               else
                  range_start[k] = IW'($urandom_range(0, 1000));
            end
            bvh_finished = (c < 4) ? 1'($urandom_range(0, 1)) : 1'b0;
            prim_ready = ($urandom_range(0, 2) != 0);
            cyc();
         end
         wait_done(300);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
